risc_trace_buffer: RTL and testbench

RISC_TRACE_BUFFER -- requirements
Module: risc_trace_buffer

---
 rtl/risc_trace_buffer_if.sv | 15 +
 rtl/risc_trace_buffer.sv | 193 +++++++++++++++++++
 tb/tb_risc_trace_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_trace_buffer_if.sv
// Readout handshake bundle of the trace buffer.
//   rd_valid : producer -> consumer, rd_data holds a stored entry
//   rd_data  : producer -> consumer, {timestamp, instr, prev_state, cu_state}
//   rd_ready : consumer -> producer, consumer accepts rd_data this cycle
// The master modport is used by the trace buffer and the slave modport by the consumer.
interface risc_trace_buffer_if #(
  parameter int ENTRY_W = 40
);
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/risc_trace_buffer.sv
// Control-unit trace buffer: records every control-unit state change as
// {timestamp, instr, prev_state, cu_state} into a circular buffer, stops a
// programmable number of entries after a trigger state, then plays the
// entries back oldest first over a valid/ready handshake.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   arm                  pulse: clear the buffer, latch post_cnt, start capture
//   instr, cu_state      observed control-unit instruction and state
//   trig_en, trig_state  trigger enable and trigger state value
//   post_cnt             entries to keep after the trigger (values above DEPTH clip to DEPTH)
//   rd_if                readout handshake (rd_valid, rd_ready, rd_data)
//   busy, done           capturing (ARMED/POST) / readout phase (DONE)
//   overflow             an entry has been overwritten since the last arm
//   level                number of stored entries
module risc_trace_buffer #(
  parameter int INSTR_W = 16,
  parameter int STATE_W = 4,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic [INSTR_W-1:0]             instr,
  input  logic [STATE_W-1:0]             cu_state,
  input  logic                           trig_en,
  input  logic [STATE_W-1:0]             trig_state,
  input  logic [$clog2(DEPTH):0]         post_cnt,
  risc_trace_buffer_if.master            rd_if,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [$clog2(DEPTH):0]         level
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = TS_W + INSTR_W + 2 * STATE_W;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [STATE_W-1:0]   prev_state_q, prev_state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     level_q, level_d, post_q, post_d, post_lat_q, post_lat_d;
  logic                 overflow_q, overflow_d, busy_q, busy_d, done_q, done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic                 change_s, capture_s;
  logic [ENTRY_W-1:0]   wr_entry_s;
  logic [CNT_W-1:0]     post_clip_s;

  assign change_s    = (cu_state != prev_state_q);
  assign wr_entry_s  = {ts_q, instr, prev_state_q, cu_state};
  assign post_clip_s = (post_cnt > DEPTH_C) ? DEPTH_C : post_cnt;

  // FSM next state, buffer pointers, level/overflow and registered readout values.
  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q + TS_ONE;
    prev_state_d = cu_state;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    post_d       = post_q;
    post_lat_d   = post_lat_q;
    overflow_d   = overflow_q;
    capture_s    = 1'b0;
    if (arm) begin
      // arm wins over any same-cycle capture, trigger or read transfer
      state_d    = ST_ARMED;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      level_d    = CNT_ZERO;
      post_d     = CNT_ZERO;
      post_lat_d = post_clip_s;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          capture_s = change_s;
          if (change_s && trig_en && (cu_state == trig_state)) begin
            if (post_lat_q == CNT_ZERO) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              post_d  = post_lat_q;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          capture_s = change_s;
          if (change_s) begin
            post_d  = post_q - CNT_ONE;
            state_d = (post_q == CNT_ONE) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_POST;
          end
        end
        ST_DONE: begin
          if (rd_valid_q && rd_if.rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            level_d  = level_q - CNT_ONE;
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (capture_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        // a full buffer drops its oldest entry, which is the slot being written
        if (level_q == DEPTH_C) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          overflow_d = 1'b1;
        end else begin
          level_d = level_q + CNT_ONE;
        end
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
    busy_d     = (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d     = (state_d == ST_DONE);
    rd_valid_d = done_d && (level_d != CNT_ZERO);
    if (!rd_valid_d) begin
      rd_data_d = {ENTRY_W{1'b0}};
    end else if (capture_s && (wr_ptr_q == rd_ptr_d)) begin
      // the entry to present is being written this very cycle
      rd_data_d = wr_entry_s;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ts_q         <= {TS_W{1'b0}};
      prev_state_q <= {STATE_W{1'b0}};
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      level_q      <= CNT_ZERO;
      post_q       <= CNT_ZERO;
      post_lat_q   <= CNT_ZERO;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= {ENTRY_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      prev_state_q <= prev_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      post_q       <= post_d;
      post_lat_q   <= post_lat_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Entry storage; contents are meaningless until written after an arm.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = rd_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign level          = level_q;
endmodule

// File: tb/tb_risc_trace_buffer.sv
// Self-checking bench for risc_trace_buffer (DEPTH=4, INSTR_W=16, STATE_W=4, TS_W=8).
// A queue-based reference model predicts every output after each clock edge;
// directed scenarios add fixed-value checks, then a randomized phase follows.
module tb_risc_trace_buffer;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DONE  = 3;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [15:0] instr;
  logic [3:0]  cu_state;
  logic        trig_en;
  logic [3:0]  trig_state;
  logic [2:0]  post_cnt;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  level;

  risc_trace_buffer_if #(.ENTRY_W(32)) rd_if ();

  risc_trace_buffer #(
    .INSTR_W(16), .STATE_W(4), .DEPTH(4), .TS_W(8)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .instr(instr), .cu_state(cu_state),
    .trig_en(trig_en), .trig_state(trig_state), .post_cnt(post_cnt),
    .rd_if(rd_if), .busy(busy), .done(done), .overflow(overflow), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_mode;
  logic [31:0] m_q[$];
  logic [7:0]  m_ts;
  logic [3:0]  m_prev;
  bit          m_ovf;
  int          m_post_lat;
  int          m_post_left;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance the model by one clock edge using the inputs applied now
  task automatic model_step();
    logic [31:0] e;
    bit change;
    if (rst) begin
      m_mode = M_IDLE; m_q.delete(); m_ts = 8'd0; m_prev = 4'd0; m_ovf = 1'b0;
      m_post_lat = 0; m_post_left = 0;
    end else begin
      change = (cu_state != m_prev);
      e = {m_ts, instr, m_prev, cu_state};
      if (arm) begin
        m_q.delete();
        m_ovf = 1'b0;
        m_post_lat = (int'(post_cnt) > 4) ? 4 : int'(post_cnt);
        m_mode = M_ARMED;
      end else if ((m_mode == M_ARMED || m_mode == M_POST) && change) begin
        m_q.push_back(e);
        if (m_q.size() > 4) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        if (m_mode == M_ARMED) begin
          if (trig_en && cu_state == trig_state) begin
            if (m_post_lat == 0) m_mode = M_DONE;
            else begin m_mode = M_POST; m_post_left = m_post_lat; end
          end
        end else begin
          m_post_left--;
          if (m_post_left == 0) m_mode = M_DONE;
        end
      end else if (m_mode == M_DONE && m_q.size() > 0 && rd_if.rd_ready) begin
        void'(m_q.pop_front());
      end
      m_ts = m_ts + 8'd1;
      m_prev = cu_state;
    end
  endtask

  task automatic compare_all();
    bit          e_valid;
    logic [31:0] e_data;
    e_valid = (m_mode == M_DONE) && (m_q.size() > 0);
    e_data  = e_valid ? m_q[0] : 32'h0;
    check_eq("busy", 64'(busy), 64'(m_mode == M_ARMED || m_mode == M_POST));
    check_eq("done", 64'(done), 64'(m_mode == M_DONE));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("level", 64'(level), 64'(m_q.size()));
    check_eq("rd_valid", 64'(rd_if.rd_valid), 64'(e_valid));
    check_eq("rd_data", 64'(rd_if.rd_data), 64'(e_data));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [3:0] cs, input logic [15:0] ins);
    cu_state = cs;
    instr    = ins;
    tick();
  endtask

  task automatic do_arm(input logic [2:0] pc, input logic te, input logic [3:0] tst);
    arm = 1'b1; post_cnt = pc; trig_en = te; trig_state = tst;
    tick();
    arm = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [15:0] ins, input logic [3:0] pv,
                            input logic [3:0] cs);
    logic [23:0] want;
    want = {ins, pv, cs};
    check_eq({tag, "_valid"}, 64'(rd_if.rd_valid), 64'(1'b1));
    check_eq({tag, "_entry"}, 64'(rd_if.rd_data[23:0]), 64'(want));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'(1'b0));
    check_eq({tag, "_done"}, 64'(done), 64'(1'b0));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(1'b0));
    check_eq({tag, "_level"}, 64'(level), 64'(3'd0));
    check_eq({tag, "_valid"}, 64'(rd_if.rd_valid), 64'(1'b0));
    check_eq({tag, "_data"}, 64'(rd_if.rd_data), 64'(32'h0));
  endtask

  // rst raised between edges; outputs must clear without a clock edge
  task automatic reset_midcycle(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; instr = 16'h0; cu_state = 4'd0; trig_en = 1'b0;
    trig_state = 4'd0; post_cnt = 3'd0; rd_if.rd_ready = 1'b0;
    #1;
    check_all_zero("por");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic trigger with no post-trigger entries
    do_arm(3'd0, 1'b1, 4'd3);
    drive(4'd0, 16'hA000);
    drive(4'd1, 16'hA001);
    drive(4'd2, 16'hA002);
    check_eq("basic_busy", 64'(busy), 64'(1'b1));
    drive(4'd3, 16'hA003);
    check_eq("basic_done", 64'(done), 64'(1'b1));
    check_eq("basic_level", 64'(level), 64'(3'd3));
    check_head("basic_e0", 16'hA001, 4'd0, 4'd1);
    rd_if.rd_ready = 1'b1;
    tick();
    check_head("basic_e1", 16'hA002, 4'd1, 4'd2);
    tick();
    check_head("basic_e2", 16'hA003, 4'd2, 4'd3);
    tick();
    check_eq("basic_empty", 64'(rd_if.rd_valid), 64'(1'b0));

    // wrap-around: six changes into four entries
    rd_if.rd_ready = 1'b0;
    drive(4'd0, 16'h0);
    do_arm(3'd0, 1'b1, 4'd6);
    for (int i = 1; i <= 6; i++) drive(4'(i), 16'hB000 + 16'(i));
    check_eq("wrap_level", 64'(level), 64'(3'd4));
    check_eq("wrap_ovf", 64'(overflow), 64'(1'b1));
    check_head("wrap_first", 16'hB003, 4'd2, 4'd3);
    rd_if.rd_ready = 1'b1;
    tick();
    check_head("wrap_second", 16'hB004, 4'd3, 4'd4);
    // arm mid-readout, with rd_ready still high
    do_arm(3'd2, 1'b1, 4'd5);
    check_eq("rearm_level", 64'(level), 64'(3'd0));
    check_eq("rearm_valid", 64'(rd_if.rd_valid), 64'(1'b0));
    check_eq("rearm_busy", 64'(busy), 64'(1'b1));
    check_eq("rearm_ovf", 64'(overflow), 64'(1'b0));
    rd_if.rd_ready = 1'b0;

    // post-trigger capture of two more entries
    drive(4'd5, 16'hC005);
    check_eq("post_busy0", 64'(busy), 64'(1'b1));
    drive(4'd5, 16'hC0FF);
    drive(4'd6, 16'hC006);
    check_eq("post_busy1", 64'(busy), 64'(1'b1));
    check_eq("post_notdone", 64'(done), 64'(1'b0));
    drive(4'd7, 16'hC007);
    check_eq("post_done", 64'(done), 64'(1'b1));
    check_eq("post_busy2", 64'(busy), 64'(1'b0));
    check_eq("post_level", 64'(level), 64'(3'd3));

    // backpressure: data holds while rd_ready is low
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head("bp_hold", 16'hC005, 4'd6, 4'd5);
    end
    rd_if.rd_ready = 1'b1;
    tick();
    check_head("bp_e1", 16'hC006, 4'd5, 4'd6);
    tick();
    check_head("bp_e2", 16'hC007, 4'd6, 4'd7);
    tick();
    check_eq("bp_empty", 64'(rd_if.rd_valid), 64'(1'b0));
    check_eq("bp_level", 64'(level), 64'(3'd0));

    // reset in POST; capture must not resume without a new arm
    rd_if.rd_ready = 1'b0;
    do_arm(3'd3, 1'b1, 4'd2);
    drive(4'd1, 16'hD001);
    drive(4'd2, 16'hD002);
    drive(4'd3, 16'hD003);
    check_eq("rstpost_busy", 64'(busy), 64'(1'b1));
    reset_midcycle("rstpost");
    drive(4'd4, 16'hD004);
    drive(4'd5, 16'hD005);
    check_eq("rstpost_nocap", 64'(level), 64'(3'd0));

    // randomized traffic, including post_cnt values above DEPTH
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        arm        = 1'b1;
        post_cnt   = 3'($urandom_range(0, 7));
        trig_en    = 1'($urandom_range(0, 3) != 0);
        trig_state = 4'($urandom_range(0, 5));
      end else begin
        arm = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) cu_state = 4'($urandom_range(0, 5));
      instr          = 16'($urandom);
      rd_if.rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset_midcycle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
